// File: rtl/dds_cmd_pkg.sv
// ---------------------------------------------------------------------------
// dds_cmd_pkg: parser states, command codes, sync marker, waveform codes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dds_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    localparam logic [7:0] CMD_FTW   = 8'h01;
    localparam logic [7:0] CMD_PHASE = 8'h02;
    localparam logic [7:0] CMD_WAVE  = 8'h03;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_SAW    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/dds_gap_timer.sv
// ---------------------------------------------------------------------------
// dds_gap_timer: inter-byte gap counter, one-cycle expire at TIMEOUT_CYC-1. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dds_gap_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int              CW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    // Saturate at LAST; the parser leaves IDLE-side on expire so run drops next cycle.
    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // A byte arriving on the terminal count wins over the timeout.
    assign expire = run && !clear && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/dds_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// dds_uart_cmd_parser: framed UART command decoder writing DDS config registers;
// DDS_CMD_TIMEOUT_EN enables the inter-byte timeout. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dds_uart_cmd_parser
    import dds_cmd_pkg::*;
#(
    parameter int         FTW_W       = 32,
    parameter int         PHASE_W     = 16,
    parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [FTW_W-1:0]   ftw,
    output logic [PHASE_W-1:0] phase_off,
    output logic [1:0]         wave_sel,
    output logic               cfg_update,
    output logic               busy,
    output logic               err_chk,
    output logic               err_cmd,
    output logic               err_timeout
);

    localparam int FTW_BYTES = FTW_W / 8;
    localparam int PH_BYTES  = PHASE_W / 8;
    localparam int SH_W      = (FTW_W > PHASE_W) ? FTW_W : PHASE_W;

    if ((FTW_W % 8) != 0 || FTW_W < 8 || FTW_W > 32 ||
        (PHASE_W % 8) != 0 || PHASE_W < 8 || PHASE_W > 16 ||
        TIMEOUT_CYC < 2) begin : g_bad_params
        $error("dds_uart_cmd_parser: illegal parameter combination");
    end

    function automatic logic [2:0] payload_len(input logic [7:0] code);
        case (code)
            CMD_FTW:   payload_len = 3'(FTW_BYTES);
            CMD_PHASE: payload_len = 3'(PH_BYTES);
            default:   payload_len = 3'd1;
        endcase
    endfunction

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      cmd_code;
    logic [2:0]      byte_cnt;
    logic [7:0]      chk_acc;
    logic [SH_W-1:0] shreg;
    logic            timeout;
    logic            do_commit;
    logic            bad_chk;
    logic            bad_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_commit = 1'b0;
        bad_chk   = 1'b0;
        bad_cmd   = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) state_nxt = CMD;
                end
                CMD: begin
                    if (rx_data inside {CMD_FTW, CMD_PHASE, CMD_WAVE}) begin
                        state_nxt = PAYLOAD;
                    end else begin
                        bad_cmd   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                PAYLOAD: begin
                    if (byte_cnt == 3'd1) state_nxt = CHK;
                end
                CHK: begin
                    if (rx_data == chk_acc) do_commit = 1'b1;
                    else                    bad_chk   = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Payload is shifted in from the top, so after N bytes it sits LSB-first
    // in the upper N*8 bits regardless of which register it targets.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_code   <= '0;
            byte_cnt   <= '0;
            chk_acc    <= '0;
            shreg      <= '0;
            ftw        <= '0;
            phase_off  <= '0;
            wave_sel   <= WAVE_SINE;
            cfg_update <= 1'b0;
            err_chk    <= 1'b0;
            err_cmd    <= 1'b0;
        end else begin
            cfg_update <= do_commit;
            err_chk    <= bad_chk;
            err_cmd    <= bad_cmd;
            if (rx_valid) begin
                case (state)
                    CMD: begin
                        cmd_code <= rx_data;
                        byte_cnt <= payload_len(rx_data);
                        chk_acc  <= rx_data;
                    end
                    PAYLOAD: begin
                        shreg    <= {rx_data, shreg[SH_W-1:8]};
                        chk_acc  <= chk_acc ^ rx_data;
                        byte_cnt <= byte_cnt - 3'd1;
                    end
                    default: ;
                endcase
            end
            if (do_commit) begin
                case (cmd_code)
                    CMD_FTW:   ftw       <= shreg[SH_W-1 -: FTW_W];
                    CMD_PHASE: phase_off <= shreg[SH_W-1 -: PHASE_W];
                    CMD_WAVE:  wave_sel  <= shreg[SH_W-8 +: 2];
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef DDS_CMD_TIMEOUT_EN
    dds_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid),
        .run    (busy),
        .expire (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout;
        end
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dds_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_dds_uart_cmd_parser: directed + random frames checked against a frame-level model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dds_uart_cmd_parser;

    localparam int         FTW_W   = 32;
    localparam int         PHASE_W = 16;
    localparam int         TO      = 50;
    localparam logic [7:0] SYNC    = 8'hA5;
`ifdef DDS_CMD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         rx_data = 8'h00;
    logic               rx_valid = 1'b0;
    logic [FTW_W-1:0]   ftw;
    logic [PHASE_W-1:0] phase_off;
    logic [1:0]         wave_sel;
    logic               cfg_update;
    logic               busy;
    logic               err_chk;
    logic               err_cmd;
    logic               err_timeout;

    dds_uart_cmd_parser #(
        .FTW_W       (FTW_W),
        .PHASE_W     (PHASE_W),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .ftw         (ftw),
        .phase_off   (phase_off),
        .wave_sel    (wave_sel),
        .cfg_update  (cfg_update),
        .busy        (busy),
        .err_chk     (err_chk),
        .err_cmd     (err_cmd),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Reference state: bytes of the open frame, plus expected outputs after the next edge
    logic [7:0]         fq[$];
    int                 gap;
    logic [FTW_W-1:0]   m_ftw;
    logic [PHASE_W-1:0] m_phase;
    logic [1:0]         m_wave;
    logic               m_cfg, m_busy, m_echk, m_ecmd, m_eto;
    int                 n_checks = 0;
    int                 n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int frame_len(input logic [7:0] code);
        case (code)
            8'h01:   return 3 + FTW_W / 8;
            8'h02:   return 3 + PHASE_W / 8;
            8'h03:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] payload_value(input int nb);
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++) v = v | (64'(fq[2 + i]) << (8 * i));
        return v;
    endfunction

    // One clock cycle: compare the previous cycle's prediction, then drive and predict.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        int          need;
        logic [7:0]  x;
        logic [63:0] val;
        @(negedge clk);
        check("ftw", 64'(ftw), 64'(m_ftw));
        check("phase_off", 64'(phase_off), 64'(m_phase));
        check("wave_sel", 64'(wave_sel), 64'(m_wave));
        check("cfg_update", 64'(cfg_update), 64'(m_cfg));
        check("busy", 64'(busy), 64'(m_busy));
        check("err_chk", 64'(err_chk), 64'(m_echk));
        check("err_cmd", 64'(err_cmd), 64'(m_ecmd));
        check("err_timeout", 64'(err_timeout), 64'(m_eto));
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        m_cfg = 1'b0; m_echk = 1'b0; m_ecmd = 1'b0; m_eto = 1'b0;
        if (r) begin
            m_ftw = '0; m_phase = '0; m_wave = '0;
            fq.delete();
            gap = 0;
        end else if (v) begin
            gap = 0;
            if (fq.size() == 0) begin
                if (d == SYNC) fq.push_back(d);
            end else begin
                fq.push_back(d);
                need = frame_len(fq[1]);
                if (need == 0) begin
                    m_ecmd = 1'b1;
                    fq.delete();
                end else if (fq.size() == need) begin
                    x = '0;
                    for (int i = 1; i < need - 1; i++) x = x ^ fq[i];
                    if (x == fq[need - 1]) begin
                        m_cfg = 1'b1;
                        val   = payload_value(need - 3);
                        case (fq[1])
                            8'h01:   m_ftw   = val[FTW_W-1:0];
                            8'h02:   m_phase = val[PHASE_W-1:0];
                            default: m_wave  = val[1:0];
                        endcase
                    end else begin
                        m_echk = 1'b1;
                    end
                    fq.delete();
                end
            end
        end else if (TO_EN && fq.size() != 0) begin
            gap++;
            if (gap == TO) begin
                m_eto = 1'b1;
                fq.delete();
                gap = 0;
            end
        end
        m_busy = (fq.size() != 0);
    endtask

    task automatic send(input byte_q_t b);
        foreach (b[i]) step(1'b1, b[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t     q;
        logic [7:0]  c, x;
        int          kind, nb;
        m_ftw = '0; m_phase = '0; m_wave = '0;
        m_cfg = 0; m_busy = 0; m_echk = 0; m_ecmd = 0; m_eto = 0;
        gap = 0;
        repeat (2) @(posedge clk);
        step(1'b0, 8'h00, 1'b0);

        // FTW frame
        send('{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09});
        step(1'b0, 8'h00, 1'b0);
        check("plan_ftw_value", 64'(ftw), 64'h12345678);
        check("plan_ftw_update", 64'(cfg_update), 64'h1);
        idle(2);

        // Phase then wave back to back
        send('{8'hA5, 8'h02, 8'h00, 8'h40, 8'h42, 8'hA5, 8'h03, 8'h02, 8'h01});
        idle(2);
        check("plan_phase_value", 64'(phase_off), 64'h4000);
        check("plan_wave_value", 64'(wave_sel), 64'h2);

        // Bad checksum, garbage + unknown command, then a good frame
        send('{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08});
        idle(2);
        send('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h07});
        idle(2);
        send('{8'hA5, 8'h03, 8'h01, 8'h02});
        idle(2);

        // Stalled frame (times out only when the feature is built in), then a full frame
        send('{8'hA5, 8'h01, 8'h78});
        idle(TO + 5);
        send('{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE});
        idle(2);

        // Reset mid-frame, then a fresh frame
        send('{8'hA5, 8'h01, 8'h78, 8'h56});
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("plan_reset_ftw", 64'(ftw), 64'h0);
        send('{8'hA5, 8'h02, 8'h34, 8'h12, 8'h02 ^ 8'h34 ^ 8'h12});
        idle(2);

        // Random frames with random gaps
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 8);
            q.delete();
            if (kind <= 3) begin
                c  = 8'($urandom_range(1, 3));
                nb = frame_len(c) - 3;
                q.push_back(SYNC);
                q.push_back(c);
                x = c;
                for (int i = 0; i < nb; i++) begin
                    q.push_back(($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom));
                    x = x ^ q[q.size() - 1];
                end
                q.push_back((kind == 3) ? (x ^ 8'($urandom_range(1, 255))) : x);
            end else if (kind == 4) begin
                c = 8'($urandom);
                if (c >= 8'h01 && c <= 8'h03) c = 8'h80;
                q.push_back(SYNC);
                q.push_back(c);
            end else if (kind == 5) begin
                for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
            end else if (kind == 6) begin
                q.push_back(SYNC);
                q.push_back(8'h01);
                q.push_back(8'($urandom));
            end
            if (kind == 7) begin
                send('{8'hA5, 8'h02, 8'($urandom)});
                step(1'b0, 8'h00, 1'b1);
            end else if (kind == 8) begin
                send('{8'hA5, 8'h01});
                idle(TO - 2 + $urandom_range(0, 2));
            end else begin
                foreach (q[i]) begin
                    if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
                    step(1'b1, q[i], 1'b0);
                end
            end
            idle(($urandom_range(0, 9) == 0) ? $urandom_range(40, 60) : $urandom_range(0, 2));
        end
        idle(TO + 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dds_uart_cmd_parser.md
Name: dds_uart_cmd_parser

Overview:
- Sits directly downstream of uart_rx and consumes its received bytes (r_data plus a one-cycle byte-valid strobe).
- Assembles framed host commands and writes the DDS configuration registers:
  - frequency tuning word
  - phase offset
  - waveform select
- Frame format: SYNC, CMD, PAYLOAD (LSB first), CHK. CHK is the XOR of CMD and all payload bytes.
- Drives the phase accumulator / waveform stage with the registers plus a one-cycle update strobe.

Parameters:
- FTW_W, 32, tuning-word width; multiple of 8, 8..32; payload bytes = FTW_W/8.
- PHASE_W, 16, phase-offset width; multiple of 8, 8..16; payload bytes = PHASE_W/8.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 100000, maximum clk cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from uart_rx (r_data).
- rx_valid  in  1  one-cycle pulse; rx_data is valid this cycle.
- ftw  out  FTW_W  frequency tuning word.
- phase_off  out  PHASE_W  phase offset.
- wave_sel  out  2  waveform select (0 sine, 1 square, 2 triangle, 3 saw).
- cfg_update  out  1  one-cycle pulse when any register is committed.
- busy  out  1  high while a frame is in progress (state != IDLE).
- err_chk  out  1  one-cycle pulse on checksum mismatch.
- err_cmd  out  1  one-cycle pulse on unknown command.
- err_timeout  out  1  one-cycle pulse on inter-byte timeout.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, shift register, byte counter, checksum accumulator and timer cleared. Reset mid-frame discards the frame with no commit and no error pulse.
- Bytes are processed only on cycles with rx_valid=1. At most one byte per cycle.
- Command codes and payload lengths:
  - 0x01 = FTW, FTW_W/8 bytes.
  - 0x02 = PHASE, PHASE_W/8 bytes.
  - 0x03 = WAVE, 1 byte; bits [1:0] used, upper bits ignored.
- FSM transitions:
  - IDLE: byte == SYNC_BYTE -> CMD. Any other byte is dropped silently.
  - CMD: known code -> latch code, set byte counter = payload length, checksum = code -> PAYLOAD. Unknown code -> pulse err_cmd next cycle -> IDLE.
  - PAYLOAD: shift the byte in LSB-first (first byte lands in bits [7:0]) and XOR it into the checksum. Go to CHK after the last byte. SYNC_BYTE inside the payload is ordinary data.
  - CHK: byte == checksum -> commit, else pulse err_chk. Either way -> IDLE.
- Commit latency: the target register and cfg_update both become valid on the clk edge one cycle after the CHK rx_valid cycle. Only the addressed register changes; the others hold.
- The FSM is back in IDLE on that same edge, so a SYNC arriving the very next cycle starts a new frame with no lost byte.
- Error pulses are exactly 1 cycle wide. Error pulses and cfg_update are never asserted together.
- busy = (state != IDLE).

Optional Feature:
- Macro: DDS_CMD_TIMEOUT_EN.
- Defined:
  - The gap timer clears on every rx_valid and counts while state != IDLE.
  - When the count reaches TIMEOUT_CYC-1 without rx_valid: FSM -> IDLE, err_timeout pulses 1 cycle, nothing is committed.
  - If rx_valid arrives in the same cycle the count reaches TIMEOUT_CYC-1, the byte wins and no timeout occurs.
- Undefined: no timer logic; err_timeout tied to 0; a frame may stall indefinitely.

Decomposition:
- Package dds_cmd_pkg holds:
  - state enum: IDLE, CMD, PAYLOAD, CHK
  - command codes: CMD_FTW=8'h01, CMD_PHASE=8'h02, CMD_WAVE=8'h03
  - default SYNC_BYTE
  - wave_sel encodings
- One sub-module, dds_gap_timer:
  - parameter TIMEOUT_CYC
  - inputs: clk, rst, clear, run
  - output: expire pulse
  - instantiated only under DDS_CMD_TIMEOUT_EN.

Test Plan:
- FTW frame A5 01 78 56 34 12 09 -> one cycle after the CHK byte: ftw=32'h12345678, cfg_update=1 for exactly 1 cycle, phase_off/wave_sel unchanged, busy=0.
- Phase A5 02 00 40 42, then wave A5 03 02 01 sent back-to-back with no idle cycles -> phase_off=16'h4000, then wave_sel=2; two separate cfg_update pulses, no byte lost.
- Bad checksum A5 01 78 56 34 12 08 -> err_chk pulse 1 cycle, ftw keeps its previous value, no cfg_update.
- Garbage 00 FF 5A then A5 07 -> garbage ignored; err_cmd pulse after the 07 byte; FSM back in IDLE; a following valid frame commits.
- With DDS_CMD_TIMEOUT_EN and TIMEOUT_CYC=50: A5 01 78, then silence -> err_timeout exactly 50 cycles after the 78 byte, busy falls, ftw unchanged; a subsequent full frame commits. Without the macro, same stimulus -> busy stays 1, err_timeout stays 0.
- rst asserted for 1 cycle after A5 01 78 56 -> all outputs 0; a fresh valid frame commits correctly; no error pulses.
